// File: rtl/ring_output_port.sv
// ring_output_port
//   Output-side controller for one ring direction of a router. Picks a packet
//   from either the ring pass-through buffer or the local injection buffer,
//   holds it in a one-entry output register, and hands it to the next router
//   with a send/ready handshake. Ring packets get their hop count decremented
//   on the way through. Local packets pass through unmodified.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   polarity              router polarity, toggles every cycle
//   ringFull/ringData     pass-through buffer status and data
//   ringRd                read strobe to pass-through buffer (combinational)
//   localFull/localData   injection buffer status and data
//   localRd               read strobe to injection buffer (combinational)
//   so                    send-out, downstream write enable (combinational)
//   ri                    ready-in, downstream buffer empty
//   dataOut               outbound packet (output register)
module ring_output_port #(
    parameter int WIDTH   = 64,
    parameter int VC_BIT  = 63,
    parameter int HOP_MSB = 55,
    parameter int HOP_LSB = 48
) (
    input  logic             clk,
    input  logic             reset,
    output logic             polarity,
    input  logic             ringFull,
    input  logic [WIDTH-1:0] ringData,
    output logic             ringRd,
    input  logic             localFull,
    input  logic [WIDTH-1:0] localData,
    output logic             localRd,
    output logic             so,
    input  logic             ri,
    output logic [WIDTH-1:0] dataOut
);

    localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

    logic             outValid;
    logic [WIDTH-1:0] outReg;
    logic             prio;       // 0: ring preferred, 1: local preferred

    logic             ringElig;
    logic             localElig;
    logic             free;
    logic             grantRing;
    logic             grantLocal;
    logic [WIDTH-1:0] ringNext;

    // A source only competes when its VC tag matches the current polarity.
    assign ringElig  = ringFull  & (ringData[VC_BIT]  == polarity);
    assign localElig = localFull & (localData[VC_BIT] == polarity);

    // A register that drains this cycle counts as free, so a new packet can
    // be loaded on the same edge the old one leaves.
    assign free = ~outValid | ri;

    // Reset gates every strobe so nothing is read or sent while reset is high.
    assign grantRing  = ~reset & free & ringElig  & (~localElig | ~prio);
    assign grantLocal = ~reset & free & localElig & (~ringElig  |  prio);

    assign ringRd  = grantRing;
    assign localRd = grantLocal;
    assign so      = ~reset & outValid & ri;
    assign dataOut = outReg;

    // Hop field decremented modulo 2^HOP_W; every other bit copied.
    always_comb begin
        ringNext                  = ringData;
        ringNext[HOP_MSB:HOP_LSB] = ringData[HOP_MSB:HOP_LSB] - HOP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            polarity <= 1'b0;
            outValid <= 1'b0;
            outReg   <= '0;
            prio     <= 1'b0;
        end else begin
            polarity <= ~polarity;
            if (grantRing) begin
                outReg   <= ringNext;
                outValid <= 1'b1;
                prio     <= 1'b1;
            end else if (grantLocal) begin
                outReg   <= localData;
                outValid <= 1'b1;
                prio     <= 1'b0;
            end else if (so) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule
